// File: rtl/rx_slot_sched_pkg.sv
// Shared ethpipe RX definitions: slot metadata record, ring size defaults,
// counter widths.
package rx_slot_sched_pkg;

   localparam int SLOTS_DEF   = 4;
   localparam int SLOT_AW_DEF = 2;
   localparam int TS_W        = 64;
   localparam int LEN_W       = 12;
   localparam int DROP_W      = 16;
   localparam int TIMER_W     = 16;

   typedef struct packed {
      logic [TS_W-1:0]  ts;
      logic [LEN_W-1:0] len;
   } slot_meta_t;

endpackage

// File: rtl/rx_slot_irq_timer.sv
// Coalescing interrupt: saturating pending-frame timer and registered irq_req
// decision from the next full-slot count.
module rx_slot_irq_timer
   import rx_slot_sched_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CNT_W-1:0]   full_cnt,
   input  logic [CNT_W-1:0]   full_next,
   input  logic               release_ok,
   input  logic [CNT_W-1:0]   thresh,
   input  logic [TIMER_W-1:0] timeout,
   output logic               irq_req
);

   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   logic [CNT_W-1:0]   eff_thresh;
   logic               irq_next;

   always_comb begin
      eff_thresh = (thresh == '0) ? CNT_W'(1) : thresh;

      // Clamp rather than hold so a lowered timeout still reaches equality.
      timer_next = timer;
      if (full_cnt == '0 || release_ok) begin
         timer_next = '0;
      end else if (timer < timeout) begin
         timer_next = timer + 1'b1;
      end else begin
         timer_next = timeout;
      end

      irq_next = (full_next >= eff_thresh) ||
                 ((full_next != '0) && (timeout != '0) && (timer == timeout));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= '0;
         irq_req <= 1'b0;
      end else begin
         timer   <= timer_next;
         irq_req <= irq_next;
      end
   end

endmodule

// File: rtl/rx_slot_sched.sv
// RX frame slot ring: hands free slots to the Ethernet writer, queues full
// slots with metadata for the host in arrival order, counts drops.
module rx_slot_sched
   import rx_slot_sched_pkg::*;
#(
   parameter int SLOTS   = SLOTS_DEF,
   parameter int SLOT_AW = SLOT_AW_DEF
) (
   input  logic               pci_clk,
   input  logic               sys_rst,
   input  logic               eth_done,
   input  logic [TS_W-1:0]    eth_timestamp,
   input  logic [LEN_W-1:0]   eth_frame_len,
   output logic [SLOT_AW-1:0] eth_wr_slot,
   output logic               eth_slot_avail,
   output logic [SLOT_AW-1:0] host_rd_slot,
   output logic               host_slot_valid,
   output logic [TS_W-1:0]    host_timestamp,
   output logic [LEN_W-1:0]   host_frame_len,
   input  logic               host_release,
   input  logic [SLOT_AW:0]   irq_thresh,
   input  logic [TIMER_W-1:0] irq_timeout,
   output logic               irq_req,
   output logic [SLOT_AW:0]   full_cnt,
   output logic [DROP_W-1:0]  drop_cnt
);

   localparam logic [SLOT_AW:0] FULL_LVL = (SLOT_AW + 1)'(SLOTS);

   logic [SLOT_AW-1:0] wp;
   logic [SLOT_AW-1:0] rp;
   logic [SLOT_AW:0]   full_next;
   logic               accept;
   logic               release_ok;
   slot_meta_t         meta [SLOTS];

   assign eth_wr_slot     = wp;
   assign host_rd_slot    = rp;
   assign eth_slot_avail  = (full_cnt != FULL_LVL);
   assign host_slot_valid = (full_cnt != '0);
   assign host_timestamp  = meta[rp].ts;
   assign host_frame_len  = meta[rp].len;

   // Availability is judged on the pre-cycle count, so a full ring drops even
   // when a release lands in the same cycle.
   assign accept     = eth_done & eth_slot_avail;
   assign release_ok = host_release & host_slot_valid;

   always_comb begin
      full_next = full_cnt;
      if (accept && !release_ok) begin
         full_next = full_cnt + 1'b1;
      end else if (!accept && release_ok) begin
         full_next = full_cnt - 1'b1;
      end
   end

   always_ff @(posedge pci_clk) begin
      if (sys_rst) begin
         wp       <= '0;
         rp       <= '0;
         full_cnt <= '0;
         drop_cnt <= '0;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            meta[i] <= '0;
         end
      end else begin
         full_cnt <= full_next;
         if (accept) begin
            meta[wp] <= '{ts: eth_timestamp, len: eth_frame_len};
            wp       <= wp + 1'b1;
         end
         if (release_ok) begin
            rp <= rp + 1'b1;
         end
         if (eth_done && !eth_slot_avail && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   rx_slot_irq_timer #(
      .CNT_W (SLOT_AW + 1)
   ) u_irq (
      .clk        (pci_clk),
      .rst        (sys_rst),
      .full_cnt   (full_cnt),
      .full_next  (full_next),
      .release_ok (release_ok),
      .thresh     (irq_thresh),
      .timeout    (irq_timeout),
      .irq_req    (irq_req)
   );

endmodule

// File: tb/tb_rx_slot_sched.sv
// Directed and randomized checks of rx_slot_sched against a queue-based
// model of the slot ring and interrupt rules.
module tb_rx_slot_sched;

   localparam int SLOTS   = 4;
   localparam int SLOT_AW = 2;

   logic                pci_clk = 1'b0;
   logic                sys_rst = 1'b0;
   logic                eth_done = 1'b0;
   logic [63:0]         eth_timestamp = '0;
   logic [11:0]         eth_frame_len = '0;
   logic [SLOT_AW-1:0]  eth_wr_slot;
   logic                eth_slot_avail;
   logic [SLOT_AW-1:0]  host_rd_slot;
   logic                host_slot_valid;
   logic [63:0]         host_timestamp;
   logic [11:0]         host_frame_len;
   logic                host_release = 1'b0;
   logic [SLOT_AW:0]    irq_thresh = 3'd4;
   logic [15:0]         irq_timeout = '0;
   logic                irq_req;
   logic [SLOT_AW:0]    full_cnt;
   logic [15:0]         drop_cnt;

   int errors = 0;
   int checks = 0;

   always #5 pci_clk = ~pci_clk;

   rx_slot_sched #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW)) dut (
      .pci_clk         (pci_clk),
      .sys_rst         (sys_rst),
      .eth_done        (eth_done),
      .eth_timestamp   (eth_timestamp),
      .eth_frame_len   (eth_frame_len),
      .eth_wr_slot     (eth_wr_slot),
      .eth_slot_avail  (eth_slot_avail),
      .host_rd_slot    (host_rd_slot),
      .host_slot_valid (host_slot_valid),
      .host_timestamp  (host_timestamp),
      .host_frame_len  (host_frame_len),
      .host_release    (host_release),
      .irq_thresh      (irq_thresh),
      .irq_timeout     (irq_timeout),
      .irq_req         (irq_req),
      .full_cnt        (full_cnt),
      .drop_cnt        (drop_cnt)
   );

   // Reference model: FIFO of frames in arrival order plus slot counters.
   typedef struct {
      logic [63:0] ts;
      logic [11:0] len;
   } ent_t;

   ent_t q[$];
   int   wr_m  = 0;
   int   rd_m  = 0;
   int   drops = 0;
   int   tmr   = 0;
   bit   irq_m = 0;

   task automatic model_step(input bit d, input logic [63:0] ts, input logic [11:0] ln,
                             input bit r, input bit rs);
      int  n, nn, eff, to, old_t;
      bit  acc, rl;
      if (rs) begin
         q.delete();
         wr_m = 0; rd_m = 0; drops = 0; tmr = 0; irq_m = 0;
         return;
      end
      n     = q.size();
      to    = int'(irq_timeout);
      acc   = d && (n < SLOTS);
      rl    = r && (n > 0);
      old_t = tmr;
      if (d && !acc && drops < 65535) drops++;
      if (n == 0 || rl) tmr = 0;
      else if (tmr < to) tmr++;
      else tmr = to;
      if (rl) begin
         void'(q.pop_front());
         rd_m = (rd_m + 1) % SLOTS;
      end
      if (acc) begin
         q.push_back('{ts: ts, len: ln});
         wr_m = (wr_m + 1) % SLOTS;
      end
      nn    = q.size();
      eff   = (irq_thresh == 0) ? 1 : int'(irq_thresh);
      irq_m = (nn >= eff) || (nn != 0 && to != 0 && old_t == to);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("full_cnt", 64'(full_cnt), 64'(q.size()));
      check("eth_slot_avail", 64'(eth_slot_avail), 64'(q.size() != SLOTS));
      check("host_slot_valid", 64'(host_slot_valid), 64'(q.size() != 0));
      check("eth_wr_slot", 64'(eth_wr_slot), 64'(wr_m));
      check("host_rd_slot", 64'(host_rd_slot), 64'(rd_m));
      check("irq_req", 64'(irq_req), 64'(irq_m));
      check("drop_cnt", 64'(drop_cnt), 64'(drops));
      if (q.size() != 0) begin
         check("host_timestamp", host_timestamp, q[0].ts);
         check("host_frame_len", 64'(host_frame_len), 64'(q[0].len));
      end
   endtask

   task automatic cycle(input bit d, input logic [63:0] ts, input logic [11:0] ln,
                        input bit r, input bit rs);
      eth_done      = d;
      eth_timestamp = ts;
      eth_frame_len = ln;
      host_release  = r;
      sys_rst       = rs;
      @(posedge pci_clk);
      model_step(d, ts, ln, r, rs);
      #1;
      eth_done     = 1'b0;
      host_release = 1'b0;
      sys_rst      = 1'b0;
      check_all();
   endtask

   initial begin
      // Reset state
      cycle(0, '0, '0, 0, 1);
      cycle(0, '0, '0, 0, 1);
      check("rst_avail", 64'(eth_slot_avail), 64'd1);
      check("rst_full", 64'(full_cnt), 64'd0);

      // Single frame into empty ring
      cycle(1, 64'h1234, 12'd60, 0, 0);
      check("t1_ts", host_timestamp, 64'h1234);
      check("t1_len", 64'(host_frame_len), 64'd60);
      check("t1_wr", 64'(eth_wr_slot), 64'd1);

      // Five frames: fill and one drop
      cycle(0, '0, '0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 64'hA000 + 64'(i), 12'(100 + i), 0, 0);
      check("t2_full", 64'(full_cnt), 64'd4);
      check("t2_avail", 64'(eth_slot_avail), 64'd0);
      check("t2_drop", 64'(drop_cnt), 64'd1);

      // Full ring: simultaneous done + release still drops
      cycle(1, 64'hBEEF, 12'd7, 1, 0);
      check("t3_rp", 64'(host_rd_slot), 64'd1);
      check("t3_full", 64'(full_cnt), 64'd3);
      check("t3_drop", 64'(drop_cnt), 64'd2);
      check("t3_ts", host_timestamp, 64'hA001);
      cycle(1, 64'hC0DE, 12'd9, 0, 0);
      check("t3_reuse_full", 64'(full_cnt), 64'd4);
      check("t3_reuse_wr", 64'(eth_wr_slot), 64'd1);
      for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);
      check("t3_last_empty", 64'(host_slot_valid), 64'd0);

      // Threshold interrupt
      irq_thresh  = 3'd2;
      irq_timeout = 16'd0;
      cycle(1, 64'h11, 12'd1, 0, 0);
      check("t4_irq0", 64'(irq_req), 64'd0);
      cycle(1, 64'h22, 12'd2, 0, 0);
      check("t4_irq1", 64'(irq_req), 64'd1);
      cycle(0, '0, '0, 1, 0);
      check("t4_irq_fall", 64'(irq_req), 64'd0);
      cycle(0, '0, '0, 1, 0);

      // Timeout interrupt
      irq_thresh  = 3'd4;
      irq_timeout = 16'd10;
      cycle(1, 64'h33, 12'd3, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, '0, '0, 0, 0);
      check("t5_irq_pre", 64'(irq_req), 64'd0);
      cycle(0, '0, '0, 0, 0);
      check("t5_irq_to", 64'(irq_req), 64'd1);
      cycle(0, '0, '0, 1, 0);
      check("t5_irq_clr", 64'(irq_req), 64'd0);

      // Reset with three slots full, eth_done in the reset cycle ignored
      irq_thresh  = 3'd2;
      irq_timeout = 16'd0;
      for (int i = 0; i < 3; i++) cycle(1, 64'h40 + 64'(i), 12'(i), 0, 0);
      cycle(1, 64'h99, 12'd5, 0, 1);
      check("t6_full", 64'(full_cnt), 64'd0);
      check("t6_valid", 64'(host_slot_valid), 64'd0);
      check("t6_irq", 64'(irq_req), 64'd0);
      check("t6_wr", 64'(eth_wr_slot), 64'd0);
      check("t6_drop", 64'(drop_cnt), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) begin
            irq_thresh  = 3'($urandom_range(0, 4));
            irq_timeout = 16'($urandom_range(0, 8));
         end
         cycle($urandom_range(0, 99) < 55,
               {$urandom, $urandom},
               12'($urandom_range(0, 4095)),
               $urandom_range(0, 99) < 45,
               $urandom_range(0, 199) < 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
